// File: rtl/div32_seq.sv
`default_nettype none
// ============================================================================
//  Module   : div32_seq (with div32_cla_adder)
//  Brief    : Sequential 32-bit unsigned restoring divider, one quotient bit
//             per clock, trial subtraction through a 32-bit CLA adder.
//  Revision : 1.0 - initial release
// ============================================================================

module div32_cla_adder (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_ci,
    output logic [31:0] o_sum,
    output logic        o_co
);
    logic [31:0] w_g;
    logic [31:0] w_p;
    logic [31:0] w_c;
    logic [8:0]  w_gc;

    assign w_g     = i_a & i_b;
    assign w_p     = i_a ^ i_b;
    assign w_gc[0] = i_ci;

    // 4-bit lookahead groups; group generate/propagate chain the groups.
    for (genvar k = 0; k < 8; k++) begin : g_group
        logic [3:0] w_gl;
        logic [3:0] w_pl;
        logic       w_cin;

        assign w_gl  = w_g[4*k +: 4];
        assign w_pl  = w_p[4*k +: 4];
        assign w_cin = w_gc[k];

        assign w_c[4*k]   = w_cin;
        assign w_c[4*k+1] = w_gl[0] | (w_pl[0] & w_cin);
        assign w_c[4*k+2] = w_gl[1] | (w_pl[1] & w_gl[0]) | (w_pl[1] & w_pl[0] & w_cin);
        assign w_c[4*k+3] = w_gl[2] | (w_pl[2] & w_gl[1]) | (w_pl[2] & w_pl[1] & w_gl[0])
                          | (w_pl[2] & w_pl[1] & w_pl[0] & w_cin);
        assign w_gc[k+1]  = w_gl[3] | (w_pl[3] & w_gl[2]) | (w_pl[3] & w_pl[2] & w_gl[1])
                          | (w_pl[3] & w_pl[2] & w_pl[1] & w_gl[0])
                          | ((&w_pl) & w_cin);
    end

    assign o_sum = w_p ^ w_c;
    assign o_co  = w_gc[8];
endmodule

module div32_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_start,
    input  logic             op_clear,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             op_done,
    output logic             busy,
    output logic             div_by_zero
);
    localparam int                 c_CNT_W     = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST_STEP = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        c_IDLE = 2'd0,
        c_EXEC = 2'd1,
        c_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_r;
    logic [WIDTH-1:0]   r_d;
    logic [c_CNT_W-1:0] r_count;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_div_by_zero;

    logic               w_msb_out;
    logic [WIDTH-1:0]   w_rs;
    logic [WIDTH-1:0]   w_trial;
    logic               w_co;
    logic               w_take;
    logic [WIDTH-1:0]   w_r_next;
    logic [WIDTH-1:0]   w_q_next;

    assign w_msb_out = r_r[WIDTH-1];
    assign w_rs      = {r_r[WIDTH-2:0], r_q[WIDTH-1]};

    div32_cla_adder u_sub (
        .i_a   (w_rs),
        .i_b   (~r_d),
        .i_ci  (1'b1),
        .o_sum (w_trial),
        .o_co  (w_co)
    );

    // A bit shifted out of R means the true partial remainder exceeds 2^32 > D,
    // so the subtraction must be taken even without a carry out.
    assign w_take   = w_msb_out | w_co;
    assign w_r_next = w_take ? w_trial : w_rs;
    assign w_q_next = {r_q[WIDTH-2:0], w_take};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= c_IDLE;
            r_q           <= '0;
            r_r           <= '0;
            r_d           <= '0;
            r_count       <= '0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else if (op_clear) begin
            r_state       <= c_IDLE;
            r_q           <= '0;
            r_r           <= '0;
            r_count       <= '0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (op_start) begin
                        if (divisor == '0) begin
                            r_quotient    <= '1;
                            r_remainder   <= dividend;
                            r_div_by_zero <= 1'b1;
                            r_state       <= c_DONE;
                        end else begin
                            r_q           <= dividend;
                            r_r           <= '0;
                            r_d           <= divisor;
                            r_count       <= '0;
                            r_div_by_zero <= 1'b0;
                            r_state       <= c_EXEC;
                        end
                    end
                end
                c_EXEC: begin
                    r_q     <= w_q_next;
                    r_r     <= w_r_next;
                    r_count <= r_count + 1'b1;
                    if (r_count == c_LAST_STEP) begin
                        r_quotient  <= w_q_next;
                        r_remainder <= w_r_next;
                        r_state     <= c_DONE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;
    assign op_done     = (r_state == c_DONE);
    assign busy        = (r_state == c_EXEC);
endmodule

`default_nettype wire

// File: tb/tb_div32_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_div32_seq
//  Brief    : Self-checking bench for div32_seq against an arithmetic model.
//  Revision : 1.0 - initial release
// ============================================================================

module tb_div32_seq;
    localparam int c_N_RAND = 1500;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_start;
    logic        op_clear;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        op_done;
    logic        busy;
    logic        div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    div32_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .op_start    (op_start),
        .op_clear    (op_clear),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .op_done     (op_done),
        .busy        (busy),
        .div_by_zero (div_by_zero)
    );

    // Starts one operation and waits (bounded) for op_done; operands are
    // scrambled right after acceptance.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic [31:0] r,
                          output logic dbz, output int edges, output int busy_cycles);
        dividend    = a;
        divisor     = b;
        op_start    = 1'b1;
        edges       = 0;
        busy_cycles = 0;
        @(posedge clk); #1;
        edges++;
        op_start = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        if (busy) busy_cycles++;
        while (!op_done && edges < 40) begin
            @(posedge clk); #1;
            edges++;
            if (busy) busy_cycles++;
        end
        q   = quotient;
        r   = remainder;
        dbz = div_by_zero;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        op_start = 1'b0;
        op_clear = 1'b0;
        dividend = '0;
        divisor  = '0;
        #1;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (op_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", op_done); end
        n_tests++; if (quotient !== 32'h0) begin n_fail++; $display("FAIL reset_q: got %h want 0", quotient); end
        n_tests++; if (remainder !== 32'h0) begin n_fail++; $display("FAIL reset_r: got %h want 0", remainder); end
        n_tests++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
    endtask

    task automatic test_div_by_zero();
        logic [31:0] q, r;
        logic        dbz;
        int          edges, bc;
        run_op(32'd5, 32'd0, q, r, dbz, edges, bc);
        n_tests++; if (edges != 1) begin n_fail++; $display("FAIL dz_latency: got %0d edges want 1", edges); end
        n_tests++; if (dbz !== 1'b1) begin n_fail++; $display("FAIL dz_flag: got %b want 1", dbz); end
        n_tests++; if (q !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dz_q: got %h want ffffffff", q); end
        n_tests++; if (r !== 32'd5) begin n_fail++; $display("FAIL dz_r: got %h want 5", r); end
        op_clear = 1'b1;
        @(posedge clk); #1;
        op_clear = 1'b0;
        n_tests++; if (op_done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL dz_clear_state: got done=%b busy=%b want 0 0", op_done, busy); end
        n_tests++; if (quotient !== 32'h0 || remainder !== 32'h0) begin n_fail++; $display("FAIL dz_clear_out: got q=%h r=%h want 0 0", quotient, remainder); end
        n_tests++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL dz_clear_flag: got %b want 0", div_by_zero); end
    endtask

    task automatic test_latency();
        logic [31:0] q, r;
        logic        dbz;
        int          edges, bc;
        run_op(32'd100, 32'd7, q, r, dbz, edges, bc);
        n_tests++; if (edges != 33) begin n_fail++; $display("FAIL lat_edges: got %0d want 33", edges); end
        n_tests++; if (bc != 32) begin n_fail++; $display("FAIL lat_busy: got %0d cycles want 32", bc); end
        n_tests++; if (q !== 32'd14) begin n_fail++; $display("FAIL lat_q: got %0d want 14", q); end
        n_tests++; if (r !== 32'd2) begin n_fail++; $display("FAIL lat_r: got %0d want 2", r); end
        n_tests++; if (dbz !== 1'b0) begin n_fail++; $display("FAIL lat_dbz: got %b want 0", dbz); end
    endtask

    task automatic test_results();
        logic [31:0] ta [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7,  32'h8000_0000};
        logic [31:0] tb [4] = '{32'd1,         32'h8000_0001, 32'd9,  32'hFFFF_FFFF};
        logic [31:0] tq [4] = '{32'hFFFF_FFFF, 32'd1,         32'd0,  32'd0};
        logic [31:0] tr [4] = '{32'd0,         32'h7FFF_FFFE, 32'd7,  32'h8000_0000};
        logic [31:0] q, r;
        logic        dbz;
        int          edges, bc;
        for (int i = 0; i < 4; i++) begin
            run_op(ta[i], tb[i], q, r, dbz, edges, bc);
            n_tests++; if (edges != 33) begin n_fail++; $display("FAIL res%0d_edges: got %0d want 33", i, edges); end
            n_tests++; if (q !== tq[i]) begin n_fail++; $display("FAIL res%0d_q: got %h want %h", i, q, tq[i]); end
            n_tests++; if (r !== tr[i]) begin n_fail++; $display("FAIL res%0d_r: got %h want %h", i, r, tr[i]); end
        end
        // Results must hold in DONE while nothing new is started.
        dividend = 32'd12;
        divisor  = 32'd0;
        repeat (3) begin
            @(posedge clk); #1;
            n_tests++;
            if (op_done !== 1'b1 || quotient !== 32'h0 || remainder !== 32'h8000_0000 || div_by_zero !== 1'b0) begin
                n_fail++;
                $display("FAIL hold: got done=%b q=%h r=%h dbz=%b want 1 0 80000000 0", op_done, quotient, remainder, div_by_zero);
            end
        end
    endtask

    task automatic test_start_ignored();
        int edges = 0;
        op_start = 1'b1;
        dividend = 32'd100;
        divisor  = 32'd7;
        do begin
            @(posedge clk); #1;
            edges++;
            op_start = (edges == 5 || edges == 6);
            dividend = 32'd5;
            divisor  = 32'd0;
        end while (!op_done && edges < 40);
        op_start = 1'b0;
        n_tests++; if (edges != 33) begin n_fail++; $display("FAIL ign_edges: got %0d want 33", edges); end
        n_tests++; if (quotient !== 32'd14 || remainder !== 32'd2) begin n_fail++; $display("FAIL ign_result: got q=%0d r=%0d want 14 2", quotient, remainder); end
        n_tests++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL ign_dbz: got %b want 0", div_by_zero); end
    endtask

    task automatic test_clear_abort();
        logic [31:0] q, r;
        logic        dbz;
        int          edges, bc;
        int          rises = 0;
        dividend = 32'd1000;
        divisor  = 32'd3;
        op_start = 1'b1;
        @(posedge clk); #1;
        op_start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        op_clear = 1'b1;
        @(posedge clk); #1;
        op_clear = 1'b0;
        n_tests++; if (busy !== 1'b0 || op_done !== 1'b0) begin n_fail++; $display("FAIL clr_state: got busy=%b done=%b want 0 0", busy, op_done); end
        n_tests++; if (quotient !== 32'h0 || remainder !== 32'h0 || div_by_zero !== 1'b0) begin n_fail++; $display("FAIL clr_out: got q=%h r=%h dbz=%b want 0 0 0", quotient, remainder, div_by_zero); end
        repeat (40) begin
            @(posedge clk); #1;
            if (op_done || busy) rises++;
        end
        n_tests++; if (rises != 0) begin n_fail++; $display("FAIL clr_quiet: got %0d active cycles want 0", rises); end
        run_op(32'd1000, 32'd3, q, r, dbz, edges, bc);
        n_tests++; if (edges != 33) begin n_fail++; $display("FAIL clr_restart_edges: got %0d want 33", edges); end
        n_tests++; if (q !== 32'd333 || r !== 32'd1) begin n_fail++; $display("FAIL clr_restart: got q=%0d r=%0d want 333 1", q, r); end
    endtask

    task automatic test_async_reset();
        dividend = 32'd50;
        divisor  = 32'd5;
        op_start = 1'b1;
        @(posedge clk); #1;
        op_start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_tests++; if (busy !== 1'b1 || quotient !== 32'd333) begin n_fail++; $display("FAIL ar_pre: got busy=%b q=%0d want 1 333", busy, quotient); end
        reset = 1'b1;
        #1;
        n_tests++; if (busy !== 1'b0 || op_done !== 1'b0) begin n_fail++; $display("FAIL ar_state: got busy=%b done=%b want 0 0", busy, op_done); end
        n_tests++; if (quotient !== 32'h0 || remainder !== 32'h0 || div_by_zero !== 1'b0) begin n_fail++; $display("FAIL ar_out: got q=%h r=%h dbz=%b want 0 0 0", quotient, remainder, div_by_zero); end
        @(negedge clk) reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (busy !== 1'b0 || op_done !== 1'b0) begin n_fail++; $display("FAIL ar_after: got busy=%b done=%b want 0 0", busy, op_done); end
    endtask

    task automatic gen_operands(output logic [31:0] a, output logic [31:0] b);
        int sel;
        sel = $urandom_range(0, 7);
        a   = $urandom;
        b   = $urandom;
        case (sel)
            0: b = 32'd1;
            1: b = a;
            2: begin
                a = $urandom_range(0, 100000);
                b = a + 32'd1 + $urandom_range(0, 1000);
            end
            3: b = 32'd0;
            4: b = $urandom_range(1, 15);
            5: b = b | 32'h8000_0000;
            default: ;
        endcase
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, eq, er;
        logic        edbz;
        logic [63:0] recon;
        int          cnt, want_edges;
        gen_operands(a, b);
        dividend = a;
        divisor  = b;
        op_start = 1'b1;
        for (int i = 0; i < c_N_RAND; i++) begin
            eq         = (b == 0) ? 32'hFFFF_FFFF : a / b;
            er         = (b == 0) ? a : a % b;
            edbz       = (b == 0);
            want_edges = (b == 0) ? 1 : 33;
            cnt        = 0;
            do begin
                @(posedge clk); #1;
                cnt++;
                if (!op_done) begin
                    dividend = $urandom;
                    divisor  = $urandom;
                end
            end while (!op_done && cnt < 40);
            n_tests++;
            if (!op_done) begin
                n_fail++;
                $display("FAIL b2b_timeout: op %0d no op_done after %0d edges", i, cnt);
                break;
            end
            n_tests++;
            if (quotient !== eq || remainder !== er || div_by_zero !== edbz || cnt != want_edges) begin
                n_fail++;
                $display("FAIL b2b_result: op %0d %h/%h got q=%h r=%h dbz=%b edges=%0d want q=%h r=%h dbz=%b edges=%0d",
                         i, a, b, quotient, remainder, div_by_zero, cnt, eq, er, edbz, want_edges);
            end
            if (b != 0) begin
                recon = 64'(quotient) * 64'(b) + 64'(remainder);
                n_tests++;
                if (recon !== 64'(a) || remainder >= b) begin
                    n_fail++;
                    $display("FAIL b2b_invariant: op %0d %h/%h got q=%h r=%h", i, a, b, quotient, remainder);
                end
            end
            gen_operands(a, b);
            dividend = a;
            divisor  = b;
        end
        op_start = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_div_by_zero();
        test_latency();
        test_results();
        test_start_ignored();
        test_clear_abort();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
